// File: rtl/rat_nway.sv
// N-way register alias table: renames LANES instructions per cycle against a
// map table and a circular free list, with in-group dependency forwarding.
module rat_nway #(
    parameter int unsigned LANES      = 2,
    parameter int unsigned ARCH_REGS  = 32,
    parameter int unsigned PHYS_REGS  = 64,
    parameter int unsigned FREE_PORTS = 2,
    localparam int unsigned AW = $clog2(ARCH_REGS),
    localparam int unsigned PW = $clog2(PHYS_REGS),
    localparam int unsigned CW = $clog2(PHYS_REGS + 1)
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic [LANES-1:0]         valid_i,
    input  logic [LANES-1:0]         wr_i,
    input  logic [LANES*AW-1:0]      rs1_i,
    input  logic [LANES*AW-1:0]      rs2_i,
    input  logic [LANES*AW-1:0]      rd_i,
    input  logic [FREE_PORTS-1:0]    free_valid_i,
    input  logic [FREE_PORTS*PW-1:0] free_preg_i,
    output logic                     ready_o,
    output logic [LANES-1:0]         valid_o,
    output logic [LANES*PW-1:0]      ps1_o,
    output logic [LANES*PW-1:0]      ps2_o,
    output logic [LANES*PW-1:0]      pd_o,
    output logic [LANES*PW-1:0]      old_pd_o
);

    logic [PW-1:0] map_q  [ARCH_REGS];
    logic [PW-1:0] map_d  [ARCH_REGS];
    logic [PW-1:0] fifo_q [PHYS_REGS];
    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [CW-1:0] count_q;

    logic [LANES-1:0] alloc;
    logic [AW-1:0]    rs1 [LANES];
    logic [AW-1:0]    rs2 [LANES];
    logic [AW-1:0]    rd  [LANES];
    logic [PW-1:0]    ps1_c [LANES];
    logic [PW-1:0]    ps2_c [LANES];
    logic [PW-1:0]    pd_c  [LANES];
    logic [PW-1:0]    old_c [LANES];

    logic [FREE_PORTS-1:0] push_en;
    logic [PW-1:0]         push_idx [FREE_PORTS];
    int unsigned           n_alloc;
    int unsigned           n_pop;
    int unsigned           n_push;

    // Circular-buffer pointer advance; n never reaches PHYS_REGS.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned n);
        int unsigned s;
        s = 32'(base) + n;
        if (s >= PHYS_REGS) s = s - PHYS_REGS;
        return PW'(s);
    endfunction

    // Allocation, source lookup with intra-group forwarding, next map, free pushes.
    always_comb begin
        n_alloc = 0;
        for (int unsigned k = 0; k < LANES; k++) begin
            rs1[k]   = rs1_i[k*AW +: AW];
            rs2[k]   = rs2_i[k*AW +: AW];
            rd[k]    = rd_i[k*AW +: AW];
            alloc[k] = valid_i[k] & wr_i[k] & (rd[k] != '0);
            pd_c[k]  = '0;
            if (alloc[k]) begin
                pd_c[k] = fifo_q[wrap_add(head_q, n_alloc)];
                n_alloc = n_alloc + 1;
            end
        end

        ready_o = (32'(count_q) >= n_alloc);
        n_pop   = ready_o ? n_alloc : 0;

        // Later lanes override earlier ones so the newest producer wins.
        for (int unsigned k = 0; k < LANES; k++) begin
            ps1_c[k] = (rs1[k] == '0) ? '0 : map_q[rs1[k]];
            ps2_c[k] = (rs2[k] == '0) ? '0 : map_q[rs2[k]];
            old_c[k] = alloc[k] ? map_q[rd[k]] : '0;
            for (int unsigned j = 0; j < k; j++) begin
                if (alloc[j] && (rd[j] == rs1[k])) ps1_c[k] = pd_c[j];
                if (alloc[j] && (rd[j] == rs2[k])) ps2_c[k] = pd_c[j];
                if (alloc[k] && alloc[j] && (rd[j] == rd[k])) old_c[k] = pd_c[j];
            end
        end

        map_d = map_q;
        if (ready_o) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (alloc[k]) map_d[rd[k]] = pd_c[k];
            end
        end

        n_push = 0;
        for (int unsigned p = 0; p < FREE_PORTS; p++) begin
            push_en[p]  = free_valid_i[p] & (free_preg_i[p*PW +: PW] != '0);
            push_idx[p] = wrap_add(tail_q, n_push);
            if (push_en[p]) n_push = n_push + 1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            for (int unsigned i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            for (int unsigned i = 0; i < PHYS_REGS; i++)
                fifo_q[i] <= (i < PHYS_REGS - ARCH_REGS) ? PW'(ARCH_REGS + i) : '0;
            head_q   <= '0;
            tail_q   <= PW'(PHYS_REGS - ARCH_REGS);
            count_q  <= CW'(PHYS_REGS - ARCH_REGS);
            valid_o  <= '0;
            ps1_o    <= '0;
            ps2_o    <= '0;
            pd_o     <= '0;
            old_pd_o <= '0;
        end else begin
            map_q <= map_d;
            for (int unsigned p = 0; p < FREE_PORTS; p++) begin
                if (push_en[p]) fifo_q[push_idx[p]] <= free_preg_i[p*PW +: PW];
            end
            head_q  <= wrap_add(head_q, n_pop);
            tail_q  <= wrap_add(tail_q, n_push);
            count_q <= CW'(32'(count_q) - n_pop + n_push);
            valid_o <= ready_o ? valid_i : '0;
            for (int unsigned k = 0; k < LANES; k++) begin
                ps1_o[k*PW +: PW]    <= ps1_c[k];
                ps2_o[k*PW +: PW]    <= ps2_c[k];
                pd_o[k*PW +: PW]     <= pd_c[k];
                old_pd_o[k*PW +: PW] <= old_c[k];
            end
        end
    end

endmodule
